apb_req_arbiter: RTL and testbench

Two-requester round-robin arbiter and APB transfer sequencer for the shared APB bus. It accepts transfer requests from two independent upstream sources, for example the summed FIFO stream and a register-configuration source. It grants one request at a time and drives the full APB SETUP/ACCESS sequence toward the slaves on `psel1`..`psel4`. It returns `pready`/`prdata` completion to the granted requester only.

---
 rtl/apb_req_arbiter.sv | 176 +++++++++++++++++
 tb/tb_apb_req_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_req_arbiter.sv
// rtl/apb_req_arbiter.sv - two-requester round-robin arbiter driving an APB SETUP/ACCESS sequence
//
// Ports:
//   pclk, prst            clock, asynchronous active-high reset
//   reqN_* (N=0,1)        request: valid/addr/wdata/write/sel in, ready/rdata/err out
//   paddr, pwdata, pwrite APB address, write data, direction (held in IDLE)
//   psel1..psel4          one-hot slave selects decoded from the latched sel
//   penable               APB enable
//   pready, prdata        slave completion and read data
//
// Optional feature macro: APB_ARB_TIMEOUT_EN (ACCESS timeout abort after TIMEOUT cycles).
module apb_req_arbiter #(
    parameter int DATA_WIDTH = 17,
    parameter int ADDR_WIDTH = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                  pclk,
    input  logic                  prst,

    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    input  logic                  req0_write,
    input  logic [1:0]            req0_sel,
    output logic                  req0_ready,
    output logic [DATA_WIDTH-1:0] req0_rdata,
    output logic                  req0_err,

    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    input  logic                  req1_write,
    input  logic [1:0]            req1_sel,
    output logic                  req1_ready,
    output logic [DATA_WIDTH-1:0] req1_rdata,
    output logic                  req1_err,

    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    output logic                  pwrite,
    output logic                  psel1,
    output logic                  psel2,
    output logic                  psel3,
    output logic                  psel4,
    output logic                  penable,
    input  logic                  pready,
    input  logic [DATA_WIDTH-1:0] prdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t                  state_q;
    logic                    grant_q;
    logic                    last_grant_q;
    logic [3:0]              psel_q;
    logic                    penable_q;
    logic [ADDR_WIDTH-1:0]   paddr_q;
    logic [DATA_WIDTH-1:0]   pwdata_q;
    logic                    pwrite_q;

    logic                    any_req;
    logic                    win;
    logic [ADDR_WIDTH-1:0]   win_addr;
    logic [DATA_WIDTH-1:0]   win_wdata;
    logic                    win_write;
    logic [1:0]              win_sel;
    logic                    abort;
    logic                    done;

    // Winner selection: a lone requester wins; on a tie the one not granted last time wins.
    always_comb begin
        any_req = req0_valid | req1_valid;
        win     = 1'b0;
        if (req0_valid && req1_valid) begin
            win = ~last_grant_q;
        end else if (req1_valid) begin
            win = 1'b1;
        end
        win_addr  = win ? req1_addr  : req0_addr;
        win_wdata = win ? req1_wdata : req0_wdata;
        win_write = win ? req1_write : req0_write;
        win_sel   = win ? req1_sel   : req0_sel;
    end

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] tmo_cnt_q;

    // Count ACCESS cycles that ended without pready; the abort fires on the
    // TIMEOUT-th ACCESS cycle unless pready arrives in that same cycle.
    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            tmo_cnt_q <= '0;
        end else if (state_q == ST_SETUP) begin
            tmo_cnt_q <= '0;
        end else if (state_q == ST_ACCESS && !pready) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    assign abort = (state_q == ST_ACCESS) && !pready && (tmo_cnt_q == CNT_W'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
    assign abort = 1'b0;
`endif

    assign done = (state_q == ST_ACCESS) && (pready || abort);

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            psel_q       <= 4'b0000;
            penable_q    <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            pwrite_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        state_q      <= ST_SETUP;
                        grant_q      <= win;
                        last_grant_q <= win;
                        paddr_q      <= win_addr;
                        pwdata_q     <= win_wdata;
                        pwrite_q     <= win_write;
                        psel_q       <= 4'b0001 << win_sel;
                        penable_q    <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    state_q   <= ST_ACCESS;
                    penable_q <= 1'b1;
                end
                ST_ACCESS: begin
                    if (done) begin
                        state_q   <= ST_IDLE;
                        psel_q    <= 4'b0000;
                        penable_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    psel_q    <= 4'b0000;
                    penable_q <= 1'b0;
                end
            endcase
        end
    end

    assign paddr   = paddr_q;
    assign pwdata  = pwdata_q;
    assign pwrite  = pwrite_q;
    assign psel1   = psel_q[0];
    assign psel2   = psel_q[1];
    assign psel3   = psel_q[2];
    assign psel4   = psel_q[3];
    assign penable = penable_q;

    // Completion goes only to the granted requester; an abort returns zero data.
    assign req0_ready = done && !grant_q;
    assign req1_ready = done &&  grant_q;
    assign req0_rdata = (req0_ready && !abort) ? prdata : '0;
    assign req1_rdata = (req1_ready && !abort) ? prdata : '0;
    assign req0_err   = req0_ready && abort;
    assign req1_err   = req1_ready && abort;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb/tb_apb_req_arbiter.sv - randomized self-checking bench for apb_req_arbiter
module tb_apb_req_arbiter;

    logic        pclk = 1'b0;
    logic        prst;
    logic [1:0]  vld;
    logic [3:0]  a   [2];
    logic [16:0] wd  [2];
    logic        wr  [2];
    logic [1:0]  s   [2];
    logic        pready;
    logic [16:0] prdata;

    wire  [1:0]  rdy;
    wire  [1:0]  err;
    wire  [16:0] rdd0, rdd1;
    wire  [3:0]  paddr;
    wire  [16:0] pwdata;
    wire         pwrite, ps1, ps2, ps3, ps4, penable;

    int n_cmp = 0;
    int n_bad = 0;
    int m_last;
    int obs_win;

    always #5 pclk = ~pclk;

    apb_req_arbiter dut (
        .pclk(pclk), .prst(prst),
        .req0_valid(vld[0]), .req0_addr(a[0]), .req0_wdata(wd[0]), .req0_write(wr[0]),
        .req0_sel(s[0]), .req0_ready(rdy[0]), .req0_rdata(rdd0), .req0_err(err[0]),
        .req1_valid(vld[1]), .req1_addr(a[1]), .req1_wdata(wd[1]), .req1_write(wr[1]),
        .req1_sel(s[1]), .req1_ready(rdy[1]), .req1_rdata(rdd1), .req1_err(err[1]),
        .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
        .psel1(ps1), .psel2(ps2), .psel3(ps3), .psel4(ps4),
        .penable(penable), .pready(pready), .prdata(prdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic gen_req(input int n);
        vld[n] = 1'b1;
        a[n]   = 4'($urandom);
        wd[n]  = 17'($urandom);
        wr[n]  = 1'($urandom);
        s[n]   = 2'($urandom);
    endtask

    // Reference rule: lone requester wins, tie goes to the one not granted last.
    // Called at a negedge with the DUT idle and at least one valid request.
    task automatic run_xfer(input int waits, input logic [16:0] rd, input bit keep);
        int          w;
        logic [3:0]  xa;
        logic [16:0] xd;
        logic        xw;
        logic [3:0]  xs;
        w      = (vld == 2'b11) ? 1 - m_last : (vld[1] ? 1 : 0);
        m_last = w;
        xa = a[w]; xd = wd[w]; xw = wr[w];
        xs = 4'b0001 << s[w];
        pready = 1'b0;
        @(posedge pclk); @(negedge pclk);
        check("setup_psel", {ps4, ps3, ps2, ps1}, xs);
        check("setup_penable", penable, 0);
        check("setup_paddr", paddr, xa);
        check("setup_pwdata", pwdata, xd);
        check("setup_pwrite", pwrite, xw);
        check("setup_ready", rdy, 0);
        for (int i = 0; i < waits; i++) begin
            @(posedge pclk); @(negedge pclk); #1;
            check("wait_psel", {ps4, ps3, ps2, ps1}, xs);
            check("wait_penable", penable, 1);
            check("wait_ready", rdy, 0);
        end
        @(posedge pclk); @(negedge pclk);
        pready = 1'b1;
        prdata = rd;
        #1;
        check("done_psel", {ps4, ps3, ps2, ps1}, xs);
        check("done_penable", penable, 1);
        check("done_ready", rdy, 2'b01 << w);
        check("done_rdata_win", (w == 1) ? rdd1 : rdd0, rd);
        check("done_rdata_other", (w == 1) ? rdd0 : rdd1, 0);
        check("done_err", err, 0);
        obs_win = rdy[1] ? 1 : 0;
        @(posedge pclk); #1;
        pready = 1'b0;
        if (!keep) begin
            vld[w] = 1'b0;
            if ($urandom_range(0, 3) != 0) gen_req(w);
        end
        @(negedge pclk);
        check("idle_psel", {ps4, ps3, ps2, ps1}, 0);
        check("idle_penable", penable, 0);
        check("idle_paddr", paddr, xa);
        check("idle_pwdata", pwdata, xd);
        check("idle_pwrite", pwrite, xw);
        check("idle_ready", rdy, 0);
    endtask

    initial begin
        prst = 1'b1; vld = 2'b00; pready = 1'b0; prdata = '0;
        for (int n = 0; n < 2; n++) begin
            a[n] = '0; wd[n] = '0; wr[n] = 1'b0; s[n] = '0;
        end
        m_last = 1;
        #1;
        check("rst_psel", {ps4, ps3, ps2, ps1}, 0);
        check("rst_penable", penable, 0);
        check("rst_paddr", paddr, 0);
        check("rst_pwdata", pwdata, 0);
        check("rst_pwrite", pwrite, 0);
        check("rst_ready", rdy, 0);
        check("rst_err", err, 0);
        @(negedge pclk); @(negedge pclk);
        prst = 1'b0;

        // Single write from req0
        a[0] = 4'h3; wd[0] = 17'h1ABCD; wr[0] = 1'b1; s[0] = 2'd0; vld = 2'b01;
        run_xfer(0, 17'h0, 0);

        // Read from req1 with three wait states
        a[1] = 4'h9; wd[1] = 17'h0; wr[1] = 1'b0; s[1] = 2'd2; vld = 2'b10;
        run_xfer(3, 17'h00055, 0);

        // Contention: both valid continuously, grants alternate starting with req0
        gen_req(0); gen_req(1); vld = 2'b11;
        for (int k = 0; k < 4; k++) begin
            run_xfer(0, 17'($urandom), 1);
            check("contention_order", obs_win, k % 2);
        end

        // Randomized traffic
        for (int k = 0; k < 40; k++) begin
            if (vld == 2'b00) begin
                @(negedge pclk);
                check("gap_psel", {ps4, ps3, ps2, ps1}, 0);
                gen_req($urandom_range(0, 1));
            end
            run_xfer($urandom_range(0, 3), 17'($urandom), 0);
        end

`ifdef APB_ARB_TIMEOUT_EN
        // Stuck slave: abort on the 15th ACCESS cycle with err and zero data
        vld = 2'b01; a[0] = 4'h5; wr[0] = 1'b0; s[0] = 2'd0;
        pready = 1'b0; prdata = 17'h1FFFF; m_last = 0;
        @(posedge pclk); @(negedge pclk);
        for (int k = 1; k <= 15; k++) begin
            @(posedge pclk); @(negedge pclk); #1;
            if (k < 15) begin
                check("tmo_wait_ready", rdy, 0);
            end else begin
                check("tmo_ready", rdy, 2'b01);
                check("tmo_err", err, 2'b01);
                check("tmo_rdata", rdd0, 0);
            end
        end
        @(posedge pclk); #1; vld = 2'b00;
        @(negedge pclk);
        check("tmo_idle_psel", {ps4, ps3, ps2, ps1}, 0);
        check("tmo_idle_penable", penable, 0);
`endif

        // Reset mid-ACCESS
        vld = 2'b10; a[1] = 4'hC; wd[1] = 17'h12345; wr[1] = 1'b1; s[1] = 2'd3;
        pready = 1'b0; m_last = 1;
        @(posedge pclk); @(negedge pclk);
        @(posedge pclk); @(negedge pclk);
        check("pre_rst_penable", penable, 1);
`ifndef APB_ARB_TIMEOUT_EN
        for (int k = 0; k < 100; k++) begin
            @(posedge pclk); @(negedge pclk);
        end
        check("stuck_penable", penable, 1);
        check("stuck_psel", {ps4, ps3, ps2, ps1}, 4'b1000);
        check("stuck_ready", rdy, 0);
`endif
        #2 prst = 1'b1;
        #1;
        check("arst_psel", {ps4, ps3, ps2, ps1}, 0);
        check("arst_penable", penable, 0);
        check("arst_paddr", paddr, 0);
        check("arst_pwdata", pwdata, 0);
        check("arst_pwrite", pwrite, 0);
        m_last = 1;
        gen_req(0); gen_req(1); vld = 2'b11;
        @(negedge pclk);
        prst = 1'b0;
        run_xfer(1, 17'($urandom), 0);
        check("post_rst_tie", obs_win, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
